// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Arbitrates the single-port 128x8 SPI data memory between the SPI slave
//   datapath (fixed priority) and the local FPGA host port. A wait counter
//   bounds host starvation. Every access takes IDLE -> ACCESS -> DONE, and all
//   outputs are registered.
//
//   Optional feature macro: DM_ARB_WRITE_PROTECT_EN
//     defined   : host writes at addr >= PROT_BASE are rejected (no mem_we,
//                 host_err pulses with host_ack)
//     undefined : no address check, host_err is constant 0
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   spi_req/we/addr/wdata -> spi_ack/spi_rdata     SPI requester
//   host_req/we/addr/wdata -> host_ack/host_rdata/host_err   host requester
//   mem_addr/mem_we/mem_wdata, mem_rdata           memory interface
//   busy                              high whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | wait for a request, arbitrate, latch the winning command
// ACCESS | drive the memory for one cycle, capture read data at its end
// DONE   | pulse the winner's ack, then return to IDLE

module dm_arbiter #(
   parameter int                ADDR_W    = 7,
   parameter int                DATA_W    = 8,
   parameter int                MAX_WAIT  = 4,
   parameter logic [ADDR_W-1:0] PROT_BASE = 7'h70
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_req,
   input  logic              spi_we,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic [DATA_W-1:0] spi_wdata,
   output logic              spi_ack,
   output logic [DATA_W-1:0] spi_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic       cmd_host;
   logic       cmd_we;
   logic       cmd_err;
   logic [3:0] wait_cnt, wait_nxt;

   logic              grant_load;
   logic              grant_host;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              reject;

   assign sel_we    = grant_host ? host_we    : spi_we;
   assign sel_addr  = grant_host ? host_addr  : spi_addr;
   assign sel_wdata = grant_host ? host_wdata : spi_wdata;

`ifdef DM_ARB_WRITE_PROTECT_EN
   assign reject = grant_host && host_we && (host_addr >= PROT_BASE);
`else
   logic unused_prot_base;
   assign reject           = 1'b0;
   assign unused_prot_base = ^PROT_BASE;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      grant_load = 1'b0;
      grant_host = 1'b0;
      wait_nxt   = wait_cnt;
      case (state)
         IDLE: begin
            if (spi_req || host_req) begin
               grant_load = 1'b1;
               // SPI has priority unless the host has already lost MAX_WAIT times
               grant_host = host_req && (!spi_req || (wait_cnt == WAIT_MAX));
               if (grant_host)
                  wait_nxt = 4'd0;
               else if (host_req && (wait_cnt != WAIT_MAX))
                  wait_nxt = wait_cnt + 4'd1;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_addr / mem_wdata double as the address and write-data command
   // registers: they are only loaded at grant, so they hold outside ACCESS.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_host   <= 1'b0;
         cmd_we     <= 1'b0;
         cmd_err    <= 1'b0;
         wait_cnt   <= 4'd0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         spi_ack    <= 1'b0;
         host_ack   <= 1'b0;
         host_err   <= 1'b0;
         spi_rdata  <= '0;
         host_rdata <= '0;
         busy       <= 1'b0;
      end else begin
         wait_cnt <= wait_nxt;
         busy     <= (state_nxt != IDLE);
         mem_we   <= 1'b0;
         spi_ack  <= 1'b0;
         host_ack <= 1'b0;
         host_err <= 1'b0;
         if (grant_load) begin
            cmd_host  <= grant_host;
            cmd_we    <= sel_we;
            cmd_err   <= reject;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we && !reject;
         end
         if (state == ACCESS) begin
            spi_ack  <= !cmd_host;
            host_ack <= cmd_host;
            host_err <= cmd_host && cmd_err;
            if (!cmd_we) begin
               if (cmd_host) host_rdata <= mem_rdata;
               else          spi_rdata  <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Arbitrates the single-port SPI data memory (128 x 8) between two requesters: the SPI slave datapath and a local FPGA host port.
- Sits between the requesters and the data memory, and owns the memory address, write-data and write-enable nets.
- The SPI side has fixed priority. A wait counter bounds host starvation.
- All outputs are registered. Each requester uses a req/ack handshake.

Parameters:
- ADDR_W, 7, memory address width.
- DATA_W, 8, memory data width.
- MAX_WAIT, 4, number of consecutive lost arbitrations after which the host wins the next arbitration. Legal range 1..15.
- PROT_BASE, 7'h70, lowest host-write-protected address. Used only with the optional feature.

Ports:
- clk  in  1  FPGA system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- spi_req  in  1  SPI access request; held until spi_ack.
- spi_we  in  1  1 = write, 0 = read; stable while spi_req is high.
- spi_addr  in  ADDR_W  SPI address; stable while spi_req is high.
- spi_wdata  in  DATA_W  SPI write data.
- spi_ack  out  1  one-cycle completion pulse.
- spi_rdata  out  DATA_W  read data; valid from spi_ack until the next SPI grant.
- host_req  in  1  host access request.
- host_we  in  1  host write/read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  host read data; same validity rule as spi_rdata.
- host_err  out  1  one-cycle pulse with host_ack when a write was rejected; tied 0 without the feature.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; combinational from mem_addr.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any cycle, including mid-access):
  - state goes to IDLE.
  - All outputs go to 0, including rdata registers, mem_addr and mem_wdata.
  - wait_cnt = 0 and the grant register is cleared.
  - An interrupted write may have had mem_we high for at most the partial cycle.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise select a winner and latch winner, we, addr and wdata into the command registers; next state is ACCESS.
- Arbitration in IDLE:
  - spi_req only: SPI wins.
  - host_req only: host wins.
  - Both requesting: SPI wins unless wait_cnt == MAX_WAIT, in which case host wins.
  - wait_cnt increments (saturating at MAX_WAIT) each time host loses while host_req is high.
  - wait_cnt clears whenever the host is granted.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata come from the command registers.
  - mem_we = latched we.
  - At the end of the cycle, mem_rdata is captured into the winner's rdata register, for reads only.
  - Next state is DONE.
- DONE (exactly one cycle):
  - The winner's ack = 1 and mem_we = 0.
  - Next state is IDLE.
- Latency: request seen in IDLE on cycle N gives ACCESS on N+1 and ack on N+2. Minimum spacing between back-to-back accesses is 3 cycles.
- Handshake rules:
  - A requester drops req on the clock edge at which it samples ack = 1.
  - A req still high in the following IDLE cycle is a new request.
  - Changing we, addr or wdata while req is high and un-acked is illegal; behaviour is undefined.
- The loser's request is not dropped. It is re-arbitrated in the next IDLE.
- The non-winning rdata register holds its value.
- mem_addr and mem_wdata hold their last values outside ACCESS. mem_we is high only in ACCESS.
- Address wrap: none. Addresses are fixed width with no arithmetic.

Optional Feature:
- Macro: DM_ARB_WRITE_PROTECT_EN.
- Defined:
  - A host write with addr >= PROT_BASE is rejected: mem_we stays 0 during its ACCESS cycle.
  - host_ack and host_err both pulse in DONE.
  - host_rdata is unchanged.
  - SPI writes are never protected.
- Undefined: no address check, host_err is constant 0, and PROT_BASE is ignored.

Test Plan:
- SPI write 0xA5 to 0x12, then SPI read 0x12 → mem_we high exactly 1 cycle in ACCESS; spi_ack 2 cycles after req is sampled; spi_rdata = 0xA5.
- spi_req and host_req both raised in the same cycle → SPI granted first, host_ack 3 cycles after spi_ack; host read of 0x12 returns 0xA5.
- spi_req held continuously (back-to-back) with host_req high, MAX_WAIT = 4 → host loses 4 arbitrations and is granted on the 5th; wait_cnt returns to 0.
- reset_n pulled low during ACCESS of a host write → all outputs 0 asynchronously, state IDLE; after release an idle bus keeps busy = 0.
- With DM_ARB_WRITE_PROTECT_EN: host write 0x3C to 0x70 → mem_we never high, host_ack = host_err = 1; a subsequent SPI read of 0x70 returns the prior value. Host write to 0x6F succeeds with host_err = 0.
- Without the macro: the same host write to 0x70 → mem_we pulses, host_err stays 0, and a read of 0x70 returns 0x3C.
